// File: rtl/hazard_sb.sv
// Hazard and forwarding unit for the 5-stage F/D/E/M/W pipeline.
// Covers the M/W->E, M->D (branch) and W->M (store data) forwarding paths,
// load-use and branch interlocks, a mult/div busy scoreboard, a whole-pipe
// freeze while memory is waiting, and a saturating stalled-cycle counter.
module hazard_sb #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BranchD,
  input  logic             MdOpD,
  input  logic             HiLoReadD,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] RtM,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             MemWriteM,
  input  logic             MdStartE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             ForwardMM,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int unsigned      MD_W    = $clog2(MD_LAT + 1);
  localparam logic [MD_W-1:0]  MD_LOAD = MD_W'(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MD_W-1:0]  mdCntQ, mdCntD;
  logic [CNT_W-1:0] stallCntQ, stallCntD;
  logic             lwStall, branchStall, mdStall, memStall;
  logic             mdAccept, anyStall;

  // Register 0 never carries a real dependency.
  function automatic logic hitM(input logic [REG_W-1:0] src);
    return (src != '0) && (src == WriteRegM) && RegWriteM;
  endfunction

  function automatic logic hitW(input logic [REG_W-1:0] src);
    return (src != '0) && (src == WriteRegW) && RegWriteW;
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    if (hitM(src)) begin
      return 2'b10;
    end else if (hitW(src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Bypass selects; M result is newer than W so it takes priority.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardMM = 1'b0;
    if (!reset) begin
      ForwardAE = fwdSel(RsE);
      ForwardBE = fwdSel(RtE);
      ForwardAD = hitM(RsD);
      ForwardBD = hitM(RtD);
      ForwardMM = hitW(RtM) && MemWriteM;
    end
  end

  // Busy is forced low in reset so a stale count can never leak out.
  assign MdBusy = !reset && (mdCntQ != '0);

  // Hazard detection terms.
  always_comb begin
    lwStall     = MemToRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
    branchStall = BranchD &&
                  ((RegWriteE && (WriteRegE != '0) &&
                    ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemToRegM && (WriteRegM != '0) &&
                    ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdStall     = (MdOpD || HiLoReadD) && (MdBusy || MdStartE);
    memStall    = MemReqM && !MemReadyM;
  end

  // Stall/flush priority: memory freeze, then front-end interlock, then run.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      // Everything held low.
    end else if (memStall) begin
      // W still advances, so feed it a bubble instead of repeating an op.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwStall || branchStall || mdStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign mdAccept = MdStartE && !StallE;
  assign anyStall = StallF || StallD || StallE || StallM;

  // Mult/div countdown; a fresh issue reloads even on the final busy cycle.
  always_comb begin
    mdCntD = mdCntQ;
    if (mdAccept) begin
      mdCntD = MD_LOAD;
    end else if (mdCntQ != '0) begin
      mdCntD = mdCntQ - MD_W'(1);
    end
  end

  // Stalled-cycle counter holds at its maximum instead of wrapping.
  always_comb begin
    stallCntD = stallCntQ;
    if (anyStall && (stallCntQ != CNT_MAX)) begin
      stallCntD = stallCntQ + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdCntQ    <= '0;
      stallCntQ <= '0;
    end else begin
      mdCntQ    <= mdCntD;
      stallCntQ <= stallCntD;
    end
  end

  assign StallCycles = stallCntQ;

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed scenarios followed by random
// stimulus, all compared against a cycle-indexed behavioural model.
module tb_hazard_sb;

  localparam int unsigned MD_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, BranchD, MdOpD, HiLoReadD;
  logic [4:0] RsD, RtD, RsE, RtE, RtM, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, MemWriteM;
  logic       MdStartE, MemReqM, MemReadyM;

  logic        StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, ForwardMM, MdBusy;
  logic [15:0] StallCycles;

  logic        sStallF, sStallD, sStallE, sStallM, sFlushE, sFlushW;
  logic [1:0]  sForwardAE, sForwardBE;
  logic        sForwardAD, sForwardBD, sForwardMM, sMdBusy;
  logic [3:0]  sStallCycles;

  hazard_sb #(.REG_W(5), .MD_LAT(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .BranchD(BranchD), .MdOpD(MdOpD), .HiLoReadD(HiLoReadD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .RtM(RtM),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .MdStartE(MdStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardMM(ForwardMM),
    .MdBusy(MdBusy), .StallCycles(StallCycles)
  );

  // Narrow-counter instance used for the saturation checks.
  hazard_sb #(.REG_W(5), .MD_LAT(MD_LAT), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .BranchD(BranchD), .MdOpD(MdOpD), .HiLoReadD(HiLoReadD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .RtM(RtM),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .MdStartE(MdStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallM(sStallM),
    .FlushE(sFlushE), .FlushW(sFlushW), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
    .ForwardAD(sForwardAD), .ForwardBD(sForwardBD), .ForwardMM(sForwardMM),
    .MdBusy(sMdBusy), .StallCycles(sStallCycles)
  );

  int checks = 0;
  int errors = 0;

  // Model state: mult/div is busy for cycles cyc < busyEnd.
  int cyc = 0;
  int busyEnd = 0;
  int cnt = 0;
  int cnt4 = 0;

  logic       eF, eD, eE, eM, eFlushE, eFlushW, eFAD, eFBD, eFMM, eBusy;
  logic [1:0] eFAE, eFBE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    if (RegWriteM && s == WriteRegM) return 2'd2;
    if (RegWriteW && s == WriteRegW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic readByD(input logic [4:0] r);
    return (r != 5'd0) && (r == RsD || r == RtD);
  endfunction

  task automatic clearInputs();
    reset = 0; BranchD = 0; MdOpD = 0; HiLoReadD = 0;
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; RtM = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; MemToRegM = 0; MemWriteM = 0;
    MdStartE = 0; MemReqM = 0; MemReadyM = 1;
  endtask

  // Let inputs settle, derive expectations from the rules, compare everything.
  task automatic settle();
    logic loadUse, brDep, mdDep, freeze;
    #4;
    {eF, eD, eE, eM, eFlushE, eFlushW, eFAD, eFBD, eFMM, eBusy} = '0;
    eFAE = 2'd0;
    eFBE = 2'd0;
    if (!reset) begin
      eBusy   = (cyc < busyEnd);
      eFAE    = refFwd(RsE);
      eFBE    = refFwd(RtE);
      eFAD    = refFwd(RsD) == 2'd2;
      eFBD    = refFwd(RtD) == 2'd2;
      eFMM    = MemWriteM && RtM != 5'd0 && RegWriteW && RtM == WriteRegW;
      loadUse = MemToRegE && RtE != 5'd0 && (RsD == RtE || RtD == RtE);
      brDep   = BranchD && ((RegWriteE && readByD(WriteRegE)) ||
                            (MemToRegM && readByD(WriteRegM)));
      mdDep   = (MdOpD || HiLoReadD) && (eBusy || MdStartE);
      freeze  = MemReqM && !MemReadyM;
      if (freeze) begin
        {eF, eD, eE, eM, eFlushW} = 5'b11111;
      end else if (loadUse || brDep || mdDep) begin
        {eF, eD, eFlushE} = 3'b111;
      end
    end
    chk("StallF", 32'(StallF), 32'(eF));
    chk("StallD", 32'(StallD), 32'(eD));
    chk("StallE", 32'(StallE), 32'(eE));
    chk("StallM", 32'(StallM), 32'(eM));
    chk("FlushE", 32'(FlushE), 32'(eFlushE));
    chk("FlushW", 32'(FlushW), 32'(eFlushW));
    chk("ForwardAE", 32'(ForwardAE), 32'(eFAE));
    chk("ForwardBE", 32'(ForwardBE), 32'(eFBE));
    chk("ForwardAD", 32'(ForwardAD), 32'(eFAD));
    chk("ForwardBD", 32'(ForwardBD), 32'(eFBD));
    chk("ForwardMM", 32'(ForwardMM), 32'(eFMM));
    chk("MdBusy", 32'(MdBusy), 32'(eBusy));
    chk("StallCycles", 32'(StallCycles), 32'(cnt));
    chk("StallCycles4", 32'(sStallCycles), 32'(cnt4));
  endtask

  // Clock edge: advance the model using the expectations of the cycle just ended.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      cnt = 0;
      cnt4 = 0;
      busyEnd = 0;
    end else begin
      if (eF || eD || eE || eM) begin
        if (cnt < 65535) cnt++;
        if (cnt4 < 15) cnt4++;
      end
      if (MdStartE && !eE) busyEnd = cyc + 1 + int'(MD_LAT);
    end
    cyc++;
    #1;
  endtask

  task automatic setLoadUse();
    MemToRegE = 1; RtE = 5'd8; RegWriteE = 1; WriteRegE = 5'd8; RsD = 5'd8;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    clearInputs();
    reset = 1;
    @(posedge clk);
    #1;

    // Reset holds every output low even with a load-use hazard present.
    setLoadUse();
    RsE = 5'd8; WriteRegM = 5'd8; RegWriteM = 1;
    settle();
    chk("rst_StallF", 32'(StallF), 32'd0);
    chk("rst_FlushE", 32'(FlushE), 32'd0);
    chk("rst_FwdAE", 32'(ForwardAE), 32'd0);
    tick();
    clearInputs();
    settle();
    chk("rst_cnt", 32'(StallCycles), 32'd0);
    tick();

    // Load-use: one bubble, then the consumer bypasses from W.
    setLoadUse();
    settle();
    chk("lu_StallF", 32'(StallF), 32'd1);
    chk("lu_StallD", 32'(StallD), 32'd1);
    chk("lu_FlushE", 32'(FlushE), 32'd1);
    tick();
    clearInputs();
    RsE = 5'd8; WriteRegW = 5'd8; RegWriteW = 1;
    settle();
    chk("lu_StallD_rel", 32'(StallD), 32'd0);
    chk("lu_FwdAE_W", 32'(ForwardAE), 32'd1);
    tick();

    // Forward priority: M beats W; register 0 never forwards.
    clearInputs();
    RsE = 5'd5; RtE = 5'd6; WriteRegM = 5'd5; WriteRegW = 5'd5;
    RegWriteM = 1; RegWriteW = 1;
    settle();
    chk("fp_AE_M", 32'(ForwardAE), 32'd2);
    chk("fp_BE_none", 32'(ForwardBE), 32'd0);
    tick();
    RsE = 5'd0; RtE = 5'd5; RegWriteM = 0;
    settle();
    chk("fp_AE_zero", 32'(ForwardAE), 32'd0);
    chk("fp_BE_W", 32'(ForwardBE), 32'd1);
    tick();

    // Mult/div: issue at cycle 0, HI/LO read held from cycle 0.
    clearInputs();
    MdStartE = 1; HiLoReadD = 1;
    for (int i = 0; i <= 5; i++) begin
      settle();
      chk("md_busy", 32'(MdBusy), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      chk("md_StallD", 32'(StallD), (i <= 4) ? 32'd1 : 32'd0);
      tick();
      MdStartE = 0;
    end

    // Memory wait during a load-use hazard: 3 frozen cycles, then the interlock.
    clearInputs();
    setLoadUse();
    MemReqM = 1; MemReadyM = 0;
    base = cnt;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_StallE", 32'(StallE), 32'd1);
      chk("mw_StallM", 32'(StallM), 32'd1);
      chk("mw_FlushW", 32'(FlushW), 32'd1);
      chk("mw_FlushE", 32'(FlushE), 32'd0);
      tick();
    end
    MemReadyM = 1;
    settle();
    chk("mw_cnt3", 32'(StallCycles), 32'(base + 3));
    chk("mw_FlushE_after", 32'(FlushE), 32'd1);
    tick();
    clearInputs();
    settle();
    chk("mw_cnt4", 32'(StallCycles), 32'(base + 4));
    tick();

    // Saturation of the 4-bit counter.
    reset = 1;
    settle();
    tick();
    clearInputs();
    setLoadUse();
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("sat_step", 32'(sStallCycles), (i < 15) ? 32'(i) : 32'd15);
      tick();
    end
    settle();
    chk("sat_hold", 32'(sStallCycles), 32'd15);
    tick();

    // Reset in the middle of a mult/div op.
    clearInputs();
    MdStartE = 1;
    settle();
    tick();
    MdStartE = 0;
    settle();
    tick();
    settle();
    chk("rm_pre_busy", 32'(MdBusy), 32'd1);
    tick();
    reset = 1;
    setLoadUse();
    MdOpD = 1;
    settle();
    chk("rm_busy", 32'(MdBusy), 32'd0);
    chk("rm_StallF", 32'(StallF), 32'd0);
    chk("rm_FlushE", 32'(FlushE), 32'd0);
    tick();
    clearInputs();
    MdOpD = 1;
    settle();
    chk("rm_busy_after", 32'(MdBusy), 32'd0);
    chk("rm_cnt_after", 32'(StallCycles), 32'd0);
    chk("rm_StallD_after", 32'(StallD), 32'd0);
    tick();

    // Random traffic with small register numbers to provoke dependencies.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      MdOpD     = ($urandom_range(0, 5) == 0);
      HiLoReadD = ($urandom_range(0, 5) == 0);
      MdStartE  = ($urandom_range(0, 5) == 0);
      RsD = 5'($urandom_range(0, 3));
      RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3));
      RtE = 5'($urandom_range(0, 3));
      RtM = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemToRegE = ($urandom_range(0, 3) == 0);
      MemToRegM = ($urandom_range(0, 3) == 0);
      MemWriteM = 1'($urandom_range(0, 1));
      MemReqM   = ($urandom_range(0, 2) == 0);
      MemReadyM = 1'($urandom_range(0, 1));
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
Parametrised hazard/forwarding unit for the 5-stage MIPS pipeline (F/D/E/M/W). It keeps the existing forwarding paths: M/W->E, M->D for branches, and W->M for store data. New in this generation:
- a multiply/divide busy scoreboard with a configurable latency, which stalls HI/LO reads and back-to-back mult/div ops;
- a memory-wait handshake that freezes the whole pipeline;
- a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register-specifier width; register 0 is hard-wired zero.
MD_LAT, 4, mult/div latency in cycles (>=1).
CNT_W, 16, stall-counter width.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
BranchD  in  1  branch resolving in D.
MdOpD  in  1  mult/div instruction in D.
HiLoReadD  in  1  mfhi/mflo in D.
RsD, RtD, RsE, RtE, RtM  in  REG_W  source specifiers per stage.
WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination specifiers.
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables.
MemToRegE, MemToRegM  in  1  load in E/M.
MemWriteM  in  1  store in M.
MdStartE  in  1  mult/div op in E.
MemReqM  in  1  M stage is accessing memory.
MemReadyM  in  1  memory completes this cycle.
StallF, StallD, StallE, StallM  out  1  active-high hold (stage register enable = ~Stall).
FlushE  out  1  insert bubble into E.
FlushW  out  1  insert bubble into W.
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M result.
ForwardAD, ForwardBD  out  1  M result -> D comparator.
ForwardMM  out  1  W result -> M store data.
MdBusy  out  1  mult/div scoreboard busy.
StallCycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if RsE!=0 && RsE==WriteRegW && RegWriteW; else 00. M has priority over W.
  - ForwardBE is the same rule using RtE.
  - ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD is the same rule using RtD.
  - ForwardMM = RtM!=0 && RtM==WriteRegW && RegWriteW && MemWriteM.
- lwStall = MemToRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchStall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemToRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
- mdStall = (MdOpD || HiLoReadD) && (MdBusy || MdStartE).
- memStall = MemReqM && !MemReadyM.
- Priority:
  - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0. It overrides all other stalls.
  - Otherwise, if lwStall|branchStall|mdStall: StallF=StallD=1, FlushE=1, StallE=StallM=FlushW=0.
  - Otherwise all stall/flush outputs are 0.
- Mult/div scoreboard:
  - Counter mdcnt is ceil(log2(MD_LAT+1)) bits wide. MdBusy = (mdcnt!=0).
  - Issue is accepted when MdStartE && !StallE. On accept, mdcnt <= MD_LAT.
  - Otherwise, if mdcnt!=0, mdcnt decrements by 1. It keeps decrementing during memStall.
  - An accept in the same cycle as mdcnt==1 reloads to MD_LAT (reload wins).
  - A HI/LO read in D therefore proceeds on the first cycle with mdcnt==0 and no MdStartE.
- StallCycles:
  - Increments by 1 on every posedge where any of StallF/StallD/StallE/StallM is 1.
  - Saturates at 2^CNT_W-1 (holds, no wrap).
  - A memStall cycle counts once, not once per stage.
- Reset (synchronous, active-high; clk/reset names as in the rest of the core):
  - On the reset cycle: mdcnt=0, StallCycles=0.
  - While reset is high, all stall/flush outputs = 0, Forward* = 0, MdBusy = 0, regardless of inputs.
  - Reset asserted mid mult/div clears busy immediately; the next cycle starts clean.
- X-safety: all outputs are defined for every input combination; no latches.

Test Plan:
- Load-use: lw $8 in E (MemToRegE=1, RtE=8), add with RsD=8 -> StallF=StallD=1, FlushE=1 for exactly 1 cycle; next cycle ForwardAE=01 when add reaches E with WriteRegW=8.
- Forward priority: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 -> ForwardAE=10. Same with RsE=0 -> 00.
- Mult/div, MD_LAT=4:
  - MdStartE pulse at cycle 0 -> MdBusy high for cycles 1-4.
  - HiLoReadD held from cycle 0 -> StallD=1 cycles 0-4, released at cycle 5.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles concurrent with lwStall -> all four stalls=1, FlushW=1, FlushE=0 for 3 cycles. StallCycles increments by exactly 3 (then +1 for the lwStall cycle that follows).
- Saturation: CNT_W=4, hold a stall 20 cycles -> StallCycles reaches 15 and holds.
- Reset mid-op: assert reset at mdcnt=2 -> next cycle MdBusy=0, StallCycles=0, all stalls=0 even with lwStall inputs active during reset.
